// File: rtl/csi2_frame_controller.sv
// csi2_frame_controller: tracks FS/FE on one virtual channel and forwards one long-packet
// data type as a first/last-marked 32-bit word stream, with sticky framing error flags.
module csi2_frame_controller #(
   parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0,
   parameter logic [5:0] DATA_TYPE       = 6'h18
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  virtual_channel,
   input  logic [15:0] word_count,
   input  logic [5:0]  image_data_type,
   input  logic        interrupt,
   input  logic [31:0] image_data,
   input  logic        image_data_enable,
   input  logic        capture_request,
   input  logic        continuous,
   input  logic [15:0] expected_lines,
   output logic        busy,
   output logic [31:0] pixel_data,
   output logic        pixel_valid,
   output logic        pixel_first,
   output logic        pixel_last,
   output logic        frame_done,
   output logic [15:0] frame_number,
   output logic [15:0] line_count,
   output logic [3:0]  error
);
   typedef enum logic [2:0] {IDLE, ARMED, FRAME, LINE, SKIP} state_t;
   state_t state, state_nx, state_beat;
   logic [15:0] remaining, remaining_nx, remaining_beat, skip_len;
   logic [15:0] expected, expected_nx, line_beat, line_nx, frame_number_nx;
   logic [31:0] pixel_data_nx;
   logic [3:0]  error_nx;
   logic first, first_nx, beat, forward, line_end, frame_done_nx;
   logic ours, is_fs, is_fe, is_long, is_image, aligned, in_frame, restart;

   assign busy     = state != IDLE;
   assign ours     = virtual_channel == VIRTUAL_CHANNEL;
   assign is_fs    = interrupt && ours && image_data_type == 6'h00;
   assign is_fe    = interrupt && ours && image_data_type == 6'h01;
   assign is_long  = interrupt && image_data_type >= 6'h10;
   assign is_image = is_long && ours && image_data_type == DATA_TYPE;
   assign aligned  = word_count != 16'd0 && word_count[1:0] == 2'b00;
   assign skip_len = 16'((17'(word_count) + 17'd3) >> 2);

   // A beat in the same cycle as a header belongs to the packet already in flight.
   assign beat           = image_data_enable && (state == LINE || state == SKIP) && remaining != 16'd0;
   assign forward        = beat && state == LINE;
   assign line_end       = forward && remaining == 16'd1;
   assign remaining_beat = beat ? remaining - 16'd1 : remaining;
   assign state_beat     = beat && remaining == 16'd1 ? FRAME : state;
   assign line_beat      = line_end && line_count != 16'hFFFF ? line_count + 16'd1 : line_count;
   assign in_frame       = state_beat == FRAME || state_beat == LINE || state_beat == SKIP;
   assign restart        = is_fs && (state_beat == ARMED || in_frame);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         remaining    <= '0;
         expected     <= '0;
         first        <= 1'b0;
         pixel_data   <= '0;
         pixel_valid  <= 1'b0;
         pixel_first  <= 1'b0;
         pixel_last   <= 1'b0;
         frame_done   <= 1'b0;
         frame_number <= '0;
         line_count   <= '0;
         error        <= '0;
      end else begin
         state        <= state_nx;
         remaining    <= remaining_nx;
         expected     <= expected_nx;
         first        <= first_nx;
         pixel_data   <= pixel_data_nx;
         pixel_valid  <= forward;
         pixel_first  <= forward && first;
         pixel_last   <= line_end;
         frame_done   <= frame_done_nx;
         frame_number <= frame_number_nx;
         line_count   <= line_nx;
         error        <= error_nx;
      end
   end

   always_comb begin
      state_nx     = state_beat;
      remaining_nx = remaining_beat;
      if (state == IDLE)
         state_nx = capture_request ? ARMED : IDLE;
      else if (restart)
         state_nx = FRAME;
      else if (interrupt && in_frame) begin
         state_nx = is_fe ? (continuous ? ARMED : IDLE) : FRAME;
         if (is_image && aligned) begin
            state_nx     = LINE;
            remaining_nx = word_count >> 2;
         end else if (is_long) begin
            state_nx     = skip_len != 16'd0 ? SKIP : FRAME;
            remaining_nx = skip_len;
         end
      end
   end

   always_comb begin
      pixel_data_nx   = forward ? image_data : pixel_data;
      first_nx        = restart || (first && !forward);
      line_nx         = restart ? 16'd0 : line_beat;
      frame_number_nx = restart ? word_count : frame_number;
      frame_done_nx   = is_fe && in_frame;
      expected_nx     = state == IDLE && capture_request ? expected_lines : expected;
      error_nx        = state == IDLE && capture_request ? 4'd0 : error | {
         in_frame && is_image && !aligned,
         in_frame && is_fs,
         interrupt && state_beat == LINE,
         frame_done_nx && expected != 16'd0 && line_beat != expected};
   end
endmodule
